// File: rtl/exu_wb_arbiter.sv
// rtl/exu_wb_arbiter.sv - register-file write-port arbiter for ALU/MEM/MULDIV/CSR results
// Fixed-priority grant with per-source aging; registered write port, 1-cycle latency.
module exu_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   src_valid_i,
    input  logic [19:0]  src_rd_i,
    input  logic [127:0] src_data_i,
    output logic [3:0]   src_ready_o,
    input  logic         wb_hold_i,
    output logic         reg_we_o,
    output logic [4:0]   reg_waddr_o,
    output logic [31:0]  reg_wdata_o,
    output logic [15:0]  conflict_cnt_o
);

    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

    logic [AW-1:0] r_age [4];
    logic          r_we;
    logic [4:0]    r_waddr;
    logic [31:0]   r_wdata;
    logic [15:0]   r_conflict_cnt;

    logic [3:0]    w_compete;
    logic [3:0]    w_zero_rd;
    logic [3:0]    w_starved;
    logic [3:0]    w_grant;
    logic [1:0]    w_sel;
    logic          w_found;
    logic          w_conflict;

    // Base order MULDIV > MEM > CSR > ALU, walked by source index.
    function automatic logic [1:0] base_idx(input int i);
        case (i)
            0:       base_idx = 2'd2;
            1:       base_idx = 2'd1;
            2:       base_idx = 2'd3;
            default: base_idx = 2'd0;
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_compete[k] = src_valid_i[k] && (src_rd_i[5*k +: 5] != 5'd0);
            w_zero_rd[k] = src_valid_i[k] && (src_rd_i[5*k +: 5] == 5'd0);
            w_starved[k] = r_age[k] >= AGE_MAX;
        end
    end

    // Starved sources first, then the plain base order.
    always_comb begin
        w_grant = 4'b0000;
        w_sel   = 2'd0;
        w_found = 1'b0;
        if (!wb_hold_i) begin
            for (int i = 0; i < 4; i++) begin
                if (!w_found && w_compete[base_idx(i)] && w_starved[base_idx(i)]) begin
                    w_found = 1'b1;
                    w_sel   = base_idx(i);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!w_found && w_compete[base_idx(i)]) begin
                    w_found = 1'b1;
                    w_sel   = base_idx(i);
                end
            end
            if (w_found) begin
                w_grant[w_sel] = 1'b1;
            end
        end
    end

    assign w_conflict  = $countones(w_compete) >= 2;
    assign src_ready_o = rst ? (w_grant | w_zero_rd) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                r_age[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!w_compete[k] || w_grant[k]) begin
                    r_age[k] <= '0;
                end else if (!wb_hold_i && r_age[k] != AGE_MAX) begin
                    r_age[k] <= r_age[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            r_we <= w_found;
            if (w_found) begin
                r_waddr <= src_rd_i[5*w_sel +: 5];
                r_wdata <= src_data_i[32*w_sel +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_conflict_cnt <= 16'd0;
        end else if (w_conflict && r_conflict_cnt != 16'hFFFF) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign reg_we_o       = r_we;
    assign reg_waddr_o    = r_waddr;
    assign reg_wdata_o    = r_wdata;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// tb/tb_exu_wb_arbiter.sv - scoreboard bench for exu_wb_arbiter
// Expected writes are queued when a grant is predicted and matched against the write port.
module tb_exu_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   src_valid_i;
    logic [19:0]  src_rd_i;
    logic [127:0] src_data_i;
    logic [3:0]   src_ready_o;
    logic         wb_hold_i;
    logic         reg_we_o;
    logic [4:0]   reg_waddr_o;
    logic [31:0]  reg_wdata_o;
    logic [15:0]  conflict_cnt_o;

    exu_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid_i    (src_valid_i),
        .src_rd_i       (src_rd_i),
        .src_data_i     (src_data_i),
        .src_ready_o    (src_ready_o),
        .wb_hold_i      (wb_hold_i),
        .reg_we_o       (reg_we_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_o    (reg_wdata_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  exp_conf = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                check("wb_we", reg_we_o, 1);
                check("wb_addr", reg_waddr_o, sb[0].rd);
                check("wb_data", reg_wdata_o, sb[0].data);
                void'(sb.pop_front());
            end else begin
                check("wb_idle", reg_we_o, 0);
            end
        end
    end

    task automatic set_src(input int k, input logic [4:0] rd, input logic [31:0] data);
        src_valid_i[k]       = 1'b1;
        src_rd_i[5*k +: 5]   = rd;
        src_data_i[32*k +: 32] = data;
    endtask

    task automatic drop_src(input int k);
        src_valid_i[k] = 1'b0;
    endtask

    task automatic clr();
        src_valid_i = '0;
        src_rd_i    = '0;
        src_data_i  = '0;
    endtask

    // Called at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic expect_cycle(input string tag, input logic [3:0] exp_ready);
        int n_comp;
        #3;
        check(tag, src_ready_o, exp_ready);
        check("conflict_cnt", conflict_cnt_o, exp_conf);
        n_comp = 0;
        for (int k = 0; k < 4; k++) begin
            if (src_valid_i[k] && src_rd_i[5*k +: 5] != 5'd0) begin
                n_comp++;
                if (exp_ready[k]) begin
                    sb.push_back('{cyc + 1, src_rd_i[5*k +: 5], src_data_i[32*k +: 32]});
                end
            end
        end
        if (!rst) exp_conf = 0;
        else if (n_comp >= 2) exp_conf++;
        @(posedge clk);
        #1;
    endtask

    // ALU (already pending) loses STARVE_LIMIT times to MULDIV, then wins; its age must be cleared by the grant.
    task automatic starve_run(input logic [4:0] base);
        for (int i = 0; i < 4; i++) begin
            set_src(2, base + 5'(i), 32'hD000_0000 + i);
            expect_cycle("starve_lose", 4'b0100);
        end
        set_src(2, base + 5'd4, 32'hD000_0004);
        expect_cycle("starve_win", 4'b0001);
        set_src(0, 5'd6, 32'hA000_0006);
        expect_cycle("age_cleared", 4'b0100);
        drop_src(2);
        expect_cycle("alu_after", 4'b0001);
        clr();
    endtask

    initial begin
        rst = 1'b0;
        wb_hold_i = 1'b0;
        clr();
        set_src(0, 5'd5, 32'h0000_5555);
        repeat (2) @(posedge clk);
        #4;
        check("rst_ready", src_ready_o, 4'b0000);
        check("rst_we", reg_we_o, 0);
        check("rst_waddr", reg_waddr_o, 0);
        check("rst_wdata", reg_wdata_o, 0);
        check("rst_conf", conflict_cnt_o, 0);
        clr();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // T1: lone ALU
        set_src(0, 5'd5, 32'h0000_1234);
        expect_cycle("t1_ready", 4'b0001);
        clr();
        expect_cycle("t1_idle", 4'b0000);

        // T2: MULDIV beats ALU
        set_src(0, 5'd3, 32'hAAAA_0003);
        set_src(2, 5'd7, 32'hBBBB_0007);
        expect_cycle("t2_muldiv", 4'b0100);
        drop_src(2);
        expect_cycle("t2_alu", 4'b0001);
        clr();
        expect_cycle("t2_idle", 4'b0000);
        check("t2_conf", conflict_cnt_o, 1);

        // Base order among MEM, CSR, ALU
        set_src(0, 5'd10, 32'h0A0A_0A0A);
        set_src(1, 5'd11, 32'h1B1B_1B1B);
        set_src(3, 5'd12, 32'h3C3C_3C3C);
        expect_cycle("ord_mem", 4'b0010);
        drop_src(1);
        expect_cycle("ord_csr", 4'b1000);
        drop_src(3);
        expect_cycle("ord_alu", 4'b0001);
        clr();

        // T3: starvation
        set_src(0, 5'd4, 32'h4444_0004);
        starve_run(5'd8);

        // T4: rd==0 source accepted alongside
        set_src(1, 5'd0, 32'hDEAD_BEEF);
        set_src(0, 5'd3, 32'h0000_0333);
        expect_cycle("t4_ready", 4'b0011);
        clr();
        wb_hold_i = 1'b1;
        set_src(1, 5'd0, 32'hDEAD_BEEF);
        expect_cycle("t4_hold_rd0", 4'b0010);
        clr();
        wb_hold_i = 1'b0;

        // T5a: hold stalls a lone ALU
        wb_hold_i = 1'b1;
        set_src(0, 5'd2, 32'h0000_0222);
        for (int i = 0; i < 3; i++) expect_cycle("t5_hold", 4'b0000);
        wb_hold_i = 1'b0;
        expect_cycle("t5_release", 4'b0001);
        clr();

        // T5b: age frozen under hold
        set_src(0, 5'd2, 32'h0000_2222);
        for (int i = 0; i < 3; i++) begin
            set_src(2, 5'd20 + 5'(i), 32'hE000_0000 + i);
            expect_cycle("t5b_lose", 4'b0100);
        end
        set_src(2, 5'd23, 32'hE000_0023);
        wb_hold_i = 1'b1;
        for (int i = 0; i < 3; i++) expect_cycle("t5b_hold", 4'b0000);
        wb_hold_i = 1'b0;
        expect_cycle("t5b_frozen", 4'b0100);
        set_src(2, 5'd24, 32'hE000_0024);
        expect_cycle("t5b_starved", 4'b0001);
        drop_src(0);
        expect_cycle("t5b_muldiv", 4'b0100);
        clr();

        // T6: reset while a write is on the port, with ALU partially aged
        set_src(0, 5'd4, 32'h6666_0004);
        set_src(2, 5'd25, 32'hF000_0025);
        expect_cycle("t6_lose0", 4'b0100);
        set_src(2, 5'd26, 32'hF000_0026);
        expect_cycle("t6_lose1", 4'b0100);
        set_src(2, 5'd27, 32'hF000_0027);
        rst = 1'b0;
        expect_cycle("t6_in_rst", 4'b0000);
        rst = 1'b1;
        check("t6_we", reg_we_o, 0);
        check("t6_waddr", reg_waddr_o, 0);
        check("t6_wdata", reg_wdata_o, 0);
        check("t6_conf", conflict_cnt_o, 0);
        starve_run(5'd25);

        expect_cycle("end_idle", 4'b0000);
        expect_cycle("end_idle", 4'b0000);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
